// File: rtl/axis_frame_streamer.sv
// rtl/axis_frame_streamer.sv - reads a frame from input RAM, streams it out over AXIS, collects the result packet
module axis_frame_streamer #(
    parameter int DATA_SIZE     = 32,
    parameter int IN_COUNT      = 784,
    parameter int OUT_COUNT     = 10,
    parameter int IN_ADR_WIDTH  = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
    parameter int OUT_ADR_WIDTH = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [IN_ADR_WIDTH-1:0]  mem_adr,
    input  logic [DATA_SIZE-1:0]     mem_data,
    output logic [DATA_SIZE-1:0]     m_axis_data,
    output logic                     m_axis_valid,
    output logic                     m_axis_last,
    input  logic                     m_axis_ready,
    input  logic [DATA_SIZE-1:0]     s_axis_data,
    input  logic                     s_axis_valid,
    input  logic                     s_axis_last,
    output logic                     s_axis_ready,
    output logic [OUT_ADR_WIDTH-1:0] res_adr,
    output logic [DATA_SIZE-1:0]     res_data,
    output logic                     res_wr
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, RECV, FIN} state_t;

    localparam logic [IN_ADR_WIDTH-1:0]  TX_LAST = IN_ADR_WIDTH'(IN_COUNT - 1);
    localparam logic [OUT_ADR_WIDTH-1:0] RX_LAST = OUT_ADR_WIDTH'(OUT_COUNT - 1);

    state_t                   state_q;
    logic [IN_ADR_WIDTH-1:0]  tx_cnt_q;
    logic [IN_ADR_WIDTH-1:0]  mem_adr_q;
    logic [OUT_ADR_WIDTH-1:0] rx_cnt_q;
    logic [OUT_ADR_WIDTH-1:0] res_adr_q;
    logic [DATA_SIZE-1:0]     m_data_q;
    logic [DATA_SIZE-1:0]     res_data_q;
    logic                     m_valid_q;
    logic                     m_last_q;
    logic                     res_wr_q;
    logic                     done_q;
    logic                     err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_cnt_q   <= '0;
            mem_adr_q  <= '0;
            rx_cnt_q   <= '0;
            res_adr_q  <= '0;
            m_data_q   <= '0;
            res_data_q <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            res_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= FETCH;
                        mem_adr_q <= '0;
                        tx_cnt_q  <= '0;
                        rx_cnt_q  <= '0;
                        err_q     <= 1'b0;
                    end
                end
                FETCH: state_q <= CAPTURE;
                CAPTURE: begin
                    m_data_q  <= mem_data;
                    m_valid_q <= 1'b1;
                    m_last_q  <= (tx_cnt_q == TX_LAST);
                    state_q   <= SEND;
                end
                SEND: begin
                    if (m_valid_q && m_axis_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        if (m_last_q) begin
                            state_q <= RECV;
                        end else begin
                            tx_cnt_q  <= tx_cnt_q + 1'b1;
                            mem_adr_q <= mem_adr_q + 1'b1;
                            state_q   <= FETCH;
                        end
                    end
                end
                RECV: begin
                    if (s_axis_valid) begin
                        res_wr_q   <= 1'b1;
                        res_adr_q  <= rx_cnt_q;
                        res_data_q <= s_axis_data;
                        // A packet that ends early or runs long is flagged; excess beats stay stalled.
                        if (s_axis_last || (rx_cnt_q == RX_LAST)) begin
                            err_q   <= (s_axis_last != (rx_cnt_q == RX_LAST));
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            rx_cnt_q <= rx_cnt_q + 1'b1;
                        end
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign mem_adr      = mem_adr_q;
    assign m_axis_data  = m_data_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign s_axis_ready = (state_q == RECV);
    assign res_adr      = res_adr_q;
    assign res_data     = res_data_q;
    assign res_wr       = res_wr_q;

endmodule

// File: tb/tb_axis_frame_streamer.sv
// tb/tb_axis_frame_streamer.sv - scoreboard bench for axis_frame_streamer (IN=5, OUT=2)
module tb_axis_frame_streamer;

    localparam int DW    = 32;
    localparam int IN_N  = 5;
    localparam int OUT_N = 2;
    localparam int IAW   = 3;
    localparam int OAW   = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           busy, done, err;
    logic [IAW-1:0] mem_adr;
    logic [DW-1:0]  mem_data = '0;
    logic [DW-1:0]  m_axis_data;
    logic           m_axis_valid, m_axis_last;
    logic           m_axis_ready;
    logic [DW-1:0]  s_axis_data = '0;
    logic           s_axis_valid = 1'b0;
    logic           s_axis_last = 1'b0;
    logic           s_axis_ready;
    logic [OAW-1:0] res_adr;
    logic [DW-1:0]  res_data;
    logic           res_wr;

    axis_frame_streamer #(
        .DATA_SIZE(DW), .IN_COUNT(IN_N), .OUT_COUNT(OUT_N),
        .IN_ADR_WIDTH(IAW), .OUT_ADR_WIDTH(OAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .mem_adr(mem_adr), .mem_data(mem_data),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .res_adr(res_adr), .res_data(res_data), .res_wr(res_wr)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [8];
    always @(posedge clk) mem_data <= mem[mem_adr];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int tx_beats = 0;
    bit ready_toggle = 1'b0;

    logic [DW:0]     tx_exp [$];
    logic [DW+OAW:0] res_exp [$];

    initial begin
        m_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_ready = ready_toggle ? ~m_axis_ready : 1'b1;
        end
    end

    bit            stall_q = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic [DW:0]   tx_e;
    logic [DW+OAW:0] res_e;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                n_checks++;
                if (!m_axis_valid || m_axis_data !== stall_data || m_axis_last !== stall_last) begin
                    n_fail++;
                    $display("FAIL tx_stable: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                             m_axis_valid, m_axis_data, m_axis_last, stall_data, stall_last);
                end
            end
            stall_q    = m_axis_valid && !m_axis_ready;
            stall_data = m_axis_data;
            stall_last = m_axis_last;
            if (m_axis_valid && m_axis_ready) begin
                tx_beats++;
                n_checks++;
                if (tx_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_extra: got beat %h last=%0b expected none", m_axis_data, m_axis_last);
                end else begin
                    tx_e = tx_exp.pop_front();
                    if ({m_axis_last, m_axis_data} !== tx_e) begin
                        n_fail++;
                        $display("FAIL tx_beat: got last=%0b data=%h expected last=%0b data=%h",
                                 m_axis_last, m_axis_data, tx_e[DW], tx_e[DW-1:0]);
                    end
                end
            end
            if (res_wr) begin
                n_checks++;
                if (res_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL res_extra: got adr=%0d data=%h expected none", res_adr, res_data);
                end else begin
                    res_e = res_exp.pop_front();
                    if ({1'b1, res_adr, res_data} !== res_e) begin
                        n_fail++;
                        $display("FAIL res_write: got adr=%0d data=%h expected adr=%0d data=%h",
                                 res_adr, res_data, res_e[DW+OAW-1:DW], res_e[DW-1:0]);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_frame();
        for (int k = 0; k < IN_N; k++) begin
            logic [DW-1:0] d;
            d = DW'((k + 1) << 20);
            tx_exp.push_back({(k == IN_N - 1) ? 1'b1 : 1'b0, d});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Presents nbeats response beats (last on last_idx, -1 for none); returns how many were taken.
    task automatic send_resp(input int nbeats, input int last_idx, output int taken, output int mism);
        bit open;
        bit acc;
        bit got;
        logic [DW-1:0] d;
        open  = 1'b1;
        taken = 0;
        mism  = 0;
        for (int i = 0; i < nbeats; i++) begin
            d   = 32'hA000_0000 + DW'(i * 16 + 7);
            acc = open && (i < OUT_N);
            s_axis_valid = 1'b1;
            s_axis_data  = d;
            s_axis_last  = (i == last_idx);
            if (acc) begin
                res_exp.push_back({1'b1, OAW'(i), d});
                if (i == last_idx || i == OUT_N - 1) open = 1'b0;
            end
            got = 1'b0;
            for (int c = 0; c < (acc ? 300 : 12); c++) begin
                @(negedge clk);
                if (s_axis_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (got) taken++;
            if (got != acc) mism++;
            @(posedge clk);
            #1;
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, err, m_axis_valid, m_axis_last, s_axis_ready, res_wr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {busy, done, err, m_axis_valid, m_axis_last, s_axis_ready, res_wr});
        end
        n_checks++;
        if ({mem_adr, res_adr, m_axis_data, res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got adr=%0d radr=%0d md=%h rd=%h expected all 0",
                     mem_adr, res_adr, m_axis_data, res_data);
        end
        rst = 1'b0;
    endtask

    task automatic frame_case(input string name, input int nbeats, input int last_idx,
                              input int exp_taken, input logic exp_err);
        int  base, taken, mism;
        bit  ok;
        base = done_cnt;
        push_frame();
        pulse_start();
        send_resp(nbeats, last_idx, taken, mism);
        wait_done(base, ok);
        n_checks++;
        if (!ok || done_cnt != base + 1) begin
            n_fail++;
            $display("FAIL %s_done: got %0d pulses expected 1", name, done_cnt - base);
        end
        n_checks++;
        if (taken != exp_taken || mism != 0) begin
            n_fail++;
            $display("FAIL %s_rx_taken: got %0d (mism %0d) expected %0d", name, taken, mism, exp_taken);
        end
        n_checks++;
        if (err !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err_busy: got err=%b busy=%b expected err=%b busy=0", name, err, busy, exp_err);
        end
        n_checks++;
        if (tx_exp.size() != 0 || res_exp.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got tx_left=%0d res_left=%0d expected 0 0",
                     name, tx_exp.size(), res_exp.size());
        end
    endtask

    task automatic test_basic();
        frame_case("basic", 2, 1, 2, 1'b0);
    endtask

    task automatic test_ready_toggle();
        ready_toggle = 1'b1;
        frame_case("toggle", 2, 1, 2, 1'b0);
        ready_toggle = 1'b0;
    endtask

    task automatic test_short_resp();
        frame_case("short", 1, 0, 1, 1'b1);
    endtask

    task automatic test_long_resp();
        frame_case("long", 3, -1, 2, 1'b1);
    endtask

    task automatic test_start_while_busy();
        int  base, taken, mism;
        bit  ok, seen;
        base = done_cnt;
        push_frame();
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (m_axis_valid) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        send_resp(2, 1, taken, mism);
        wait_done(base, ok);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!seen || !ok || done_cnt != base + 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start: got pulses=%0d busy=%b seen=%0b expected pulses=1 busy=0",
                     done_cnt - base, busy, seen);
        end
        n_checks++;
        if (err !== 1'b0 || taken != 2 || tx_exp.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start_frame: got err=%b taken=%0d tx_left=%0d expected 0 2 0",
                     err, taken, tx_exp.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int  base, beats0;
        bit  seen;
        base   = done_cnt;
        beats0 = tx_beats;
        push_frame();
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (tx_beats == beats0 + 1 && m_axis_valid) begin
                seen = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (!seen || m_axis_valid !== 1'b0 || busy !== 1'b0 || mem_adr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got seen=%0b valid=%b busy=%b adr=%0d expected 1 0 0 0",
                     seen, m_axis_valid, busy, mem_adr);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != base || res_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got pulses=%0d res_wr=%b expected 0 0", done_cnt - base, res_wr);
        end
        tx_exp.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        frame_case("replay", 2, 1, 2, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mem[k] = DW'((k + 1) << 20);
        test_reset();
        test_basic();
        test_ready_toggle();
        test_short_resp();
        test_long_resp();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
